// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int unsigned CH_N = 4;

    typedef logic [1:0] ch_sel_t;

endpackage

// File: rtl/stream_demux_1x4_if.sv
// Producer/consumer bundle for stream_demux_1x4.
// slave: the demux side. master: the producer/consumer side.
interface stream_demux_1x4_if #(
    parameter int unsigned DATA_W = 8
);
    import demux_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    ch_sel_t                  in_sel;
    logic [CH_N-1:0]          out_valid;
    logic [CH_N-1:0]          out_ready;
    logic [CH_N*DATA_W-1:0]   out_data;

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/demux_out_slot.sv
// One-entry valid/ready output register for a single demux channel.
// free is high when the slot can take a new beat this cycle (empty or draining).
module demux_out_slot #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              free
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Occupancy: a load wins over a drain so back-to-back beats leave no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Payload register; keeps its last value when empty, so no reset is needed.
    always_ff @(posedge clk) begin
        if (load) begin
            r_data <= load_data;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign free      = ~r_valid | out_ready;

endmodule

// File: rtl/stream_demux_1x4.sv
// Registered 1-to-4 stream demultiplexer with valid/ready on input and outputs.
// Optional feature: define DEMUX_RR_EN to route beats round-robin (in_sel ignored).
module stream_demux_1x4
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    stream_demux_1x4_if.slave  bus
);

    ch_sel_t                 w_dest;
    logic [CH_N-1:0]         w_free;
    logic [CH_N-1:0]         w_load;
    logic [CH_N-1:0]         w_valid;
    logic [CH_N*DATA_W-1:0]  w_data;
    logic                    w_in_ready;
    logic                    w_accept;

`ifdef DEMUX_RR_EN
    ch_sel_t r_rr_ptr;
    logic    w_unused_sel;

    // Round-robin pointer advances only when a beat is actually accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= r_rr_ptr + 2'd1;
        end
    end

    assign w_dest       = r_rr_ptr;
    assign w_unused_sel = ^bus.in_sel;
`else
    assign w_dest = bus.in_sel;
`endif

    assign w_in_ready = ~rst & w_free[w_dest];
    assign w_accept   = bus.in_valid & w_in_ready;

    // Destination decode: one-hot load strobe for the selected slot.
    always_comb begin
        w_load         = '0;
        w_load[w_dest] = w_accept;
    end

    for (genvar n = 0; n < CH_N; n++) begin : g_slot
        demux_out_slot #(
            .DATA_W    (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (w_load[n]),
            .load_data (bus.in_data),
            .out_ready (bus.out_ready[n]),
            .out_valid (w_valid[n]),
            .out_data  (w_data[n*DATA_W +: DATA_W]),
            .free      (w_free[n])
        );
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_data;

endmodule

// File: tb/tb_stream_demux_1x4.sv
// Directed self-checking bench for stream_demux_1x4 (both DEMUX_RR_EN builds).
module tb_stream_demux_1x4;

    localparam int unsigned DW = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    stream_demux_1x4_if #(.DATA_W(DW)) bus ();

    stream_demux_1x4 #(.DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] ch_data(input int n);
        logic [4*DW-1:0] d;
        d = bus.out_data;
        return d[n*DW +: DW];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        n_checks          = 0;
        n_errors          = 0;
        rst               = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.in_sel        = '0;
        bus.out_ready     = 4'b0000;
        do_reset();

`ifndef DEMUX_RR_EN
        // Single beat to channel 2, consumer always ready.
        bus.out_ready = 4'b1111;
        bus.in_sel    = 2'd2;
        bus.in_data   = 8'hA5;
        bus.in_valid  = 1'b1;
        chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid  = 1'b0;
        chk("t1_valid", 32'(bus.out_valid), 32'b0100);
        chk("t1_data2", 32'(ch_data(2)), 32'hA5);
        step();
        chk("t1_valid_clr", 32'(bus.out_valid), 32'b0000);

        // Back-pressure on channel 1, then simultaneous drain and reload.
        bus.out_ready = 4'b1101;
        bus.in_sel    = 2'd1;
        bus.in_data   = 8'h11;
        bus.in_valid  = 1'b1;
        chk("t2_rdy_first", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_data   = 8'h22;
        chk("t2_valid1", 32'(bus.out_valid), 32'b0010);
        chk("t2_data1", 32'(ch_data(1)), 32'h11);
        chk("t2_rdy_stall", 32'(bus.in_ready), 32'd0);
        step();
        chk("t2_data_held", 32'(ch_data(1)), 32'h11);
        chk("t2_rdy_stall2", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 4'b1111;
        #1;
        chk("t2_rdy_drain", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid  = 1'b0;
        chk("t2_valid_kept", 32'(bus.out_valid), 32'b0010);
        chk("t2_data22", 32'(ch_data(1)), 32'h22);
        step();
        chk("t2_valid_clr", 32'(bus.out_valid), 32'b0000);

        // Back-to-back beats to channels 0..3.
        for (int i = 0; i < 4; i++) begin
            bus.in_sel   = 2'(i);
            bus.in_data  = 8'(i + 1);
            bus.in_valid = 1'b1;
            #1;
            chk("t3_rdy", 32'(bus.in_ready), 32'd1);
            step();
            chk("t3_valid", 32'(bus.out_valid), 32'(1 << i));
            chk("t3_data", 32'(ch_data(i)), 32'(i + 1));
        end
        bus.in_valid = 1'b0;
        step();
        chk("t3_valid_clr", 32'(bus.out_valid), 32'b0000);

        // Reset drops a buffered beat; in_ready forced low during reset.
        bus.out_ready = 4'b0111;
        bus.in_sel    = 2'd3;
        bus.in_data   = 8'h5A;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        chk("t4_filled", 32'(bus.out_valid), 32'b1000);
        step();
        chk("t4_held", 32'(bus.out_valid), 32'b1000);
        rst           = 1'b1;
        bus.out_ready = 4'b1111;
        bus.in_sel    = 2'd0;
        bus.in_valid  = 1'b1;
        #1;
        chk("t4_rdy_in_rst", 32'(bus.in_ready), 32'd0);
        step();
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        chk("t4_valid_rst", 32'(bus.out_valid), 32'b0000);
        step();
        chk("t4_no_accept", 32'(bus.out_valid), 32'b0000);
`else
        // Round-robin delivery, in_sel held at 0.
        bus.out_ready = 4'b1111;
        bus.in_sel    = 2'd0;
        for (int i = 0; i < 6; i++) begin
            bus.in_data  = 8'(8'h10 + i);
            bus.in_valid = 1'b1;
            #1;
            chk("rr_rdy", 32'(bus.in_ready), 32'd1);
            step();
            chk("rr_valid", 32'(bus.out_valid), 32'(1 << (i % 4)));
            chk("rr_data", 32'(ch_data(i % 4)), 32'(8'h10 + i));
        end
        bus.in_valid = 1'b0;
        do_reset();

        // Channel 1 stalled: pointer wraps back to 1 and the input stalls there.
        bus.out_ready = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            bus.in_data  = 8'(8'h40 + i);
            bus.in_valid = 1'b1;
            #1;
            chk("rrs_rdy", 32'(bus.in_ready), 32'd1);
            step();
        end
        bus.in_data = 8'h45;
        chk("rrs_stall", 32'(bus.in_ready), 32'd0);
        chk("rrs_data1", 32'(ch_data(1)), 32'h41);
        step();
        chk("rrs_stall2", 32'(bus.in_ready), 32'd0);
        chk("rrs_no_ch2", 32'(bus.out_valid), 32'b0010);
        bus.out_ready = 4'b1111;
        #1;
        chk("rrs_rdy_drain", 32'(bus.in_ready), 32'd1);
        step();
        chk("rrs_valid1", 32'(bus.out_valid), 32'b0010);
        chk("rrs_data45", 32'(ch_data(1)), 32'h45);
        bus.in_data = 8'h46;
        step();
        bus.in_valid = 1'b0;
        chk("rrs_ch2", 32'(bus.out_valid), 32'b0100);
        chk("rrs_data46", 32'(ch_data(2)), 32'h46);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
